// File: rtl/comparator_pkg.sv
// Shared types and constants for the cascaded magnitude comparator.
// The struct is the cascade currency between 4-bit slices and the output register.
package comparator_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Top slice sees "everything above me is equal".
  localparam cmp_res_t CMP_EQ_INIT = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};

  // Resolve one nibble given the verdict of the more-significant slices.
  function automatic cmp_res_t resolve_nibble(
    input logic [SLICE_W-1:0] a_nib,
    input logic [SLICE_W-1:0] b_nib,
    input cmp_res_t           cas_in
  );
    cmp_res_t res;
    res = cas_in;
    if (!cas_in.gt && !cas_in.lt) begin
      res.gt = (a_nib > b_nib);
      res.lt = (a_nib < b_nib);
      res.eq = (a_nib == b_nib);
    end
    return res;
  endfunction

endpackage

// File: rtl/comparator_slice.sv
// 4-bit combinational comparator slice; a decided gt/lt from above passes through,
// otherwise this nibble decides.
module comparator_slice
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  cmp_res_t           cas_in,
  output cmp_res_t           cas_out
);

  always_comb begin
    cas_out = resolve_nibble(a, b, cas_in);
  end

endmodule

// File: rtl/comparator.sv
// Registered WIDTH-bit magnitude comparator, unsigned or two's-complement per transaction.
// Handshake: a, b, is_signed are sampled when in_valid=1 at a rising edge; out_valid=1 on the
// following cycle marks the flags as that transaction's result. No backpressure.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             alb,
  output logic             aeb,
  output logic             out_valid
);

  localparam int NSLICE = WIDTH / SLICE_W;

  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;
  logic [WIDTH-1:0] sign_flip;
  cmp_res_t         chain [NSLICE+1];
  cmp_res_t         result;
  cmp_res_t         flags_q;
  logic             valid_q;

  // Offset-binary: flipping both MSBs turns a signed compare into an unsigned one.
  assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};
  assign a_adj     = a ^ sign_flip;
  assign b_adj     = b ^ sign_flip;

  assign chain[NSLICE] = CMP_EQ_INIT;

  // chain[i+1] comes from the more-significant neighbour; chain[0] is the final verdict.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    comparator_slice u_slice (
      .a       (a_adj[i*SLICE_W +: SLICE_W]),
      .b       (b_adj[i*SLICE_W +: SLICE_W]),
      .cas_in  (chain[i+1]),
      .cas_out (chain[i])
    );
  end

  assign result = chain[0];

  // Flags only load on valid cycles, so idle cycles (and junk operands) leave them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        flags_q <= result;
      end
    end
  end

  assign agb       = flags_q.gt;
  assign alb       = flags_q.lt;
  assign aeb       = flags_q.eq;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_comparator.sv
// Directed + random bench for comparator at WIDTH=4 and WIDTH=8 with a queue scoreboard.
module tb_comparator;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid4, sgn4;
  logic [3:0] a4, b4;
  logic       agb4, alb4, aeb4, out_valid4;

  logic       in_valid8, sgn8;
  logic [7:0] a8, b8;
  logic       agb8, alb8, aeb8, out_valid8;

  logic [2:0] exp_q4[$];
  logic [2:0] exp_q8[$];
  logic [2:0] last4;
  logic [2:0] last8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .is_signed(sgn4),
    .a(a4), .b(b4), .agb(agb4), .alb(alb4), .aeb(aeb4), .out_valid(out_valid4)
  );

  comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .is_signed(sgn8),
    .a(a8), .b(b8), .agb(agb8), .alb(alb8), .aeb(aeb8), .out_valid(out_valid8)
  );

  // Reference: native integer compare, {agb, alb, aeb}.
  function automatic logic [2:0] model(input longint sa, input longint sb);
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
    if (s) return model(longint'($signed(a)), longint'($signed(b)));
    return model(longint'(a), longint'(b));
  endfunction

  function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    if (s) return model(longint'($signed(a)), longint'($signed(b)));
    return model(longint'(a), longint'(b));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [2:0] e;
    @(negedge clk);
    a4 = a; b4 = b; sgn4 = s; in_valid4 = 1'b1;
    exp_q4.push_back(model4(a, b, s));
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    check("out_valid4", 8'(out_valid4), 8'd1);
    e = exp_q4.pop_front();
    last4 = e;
    check($sformatf("flags4 a=%h b=%h s=%0d", a, b, s), 8'({agb4, alb4, aeb4}), 8'(e));
  endtask

  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [2:0] e;
    @(negedge clk);
    a8 = a; b8 = b; sgn8 = s; in_valid8 = 1'b1;
    exp_q8.push_back(model8(a, b, s));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    check("out_valid8", 8'(out_valid8), 8'd1);
    e = exp_q8.pop_front();
    last8 = e;
    check($sformatf("flags8 a=%h b=%h s=%0d", a, b, s), 8'({agb8, alb8, aeb8}), 8'(e));
  endtask

  initial begin
    // Reset held with a live transaction on the inputs.
    reset = 1'b0;
    a4 = 4'b0001; b4 = 4'b0100; sgn4 = 1'b0; in_valid4 = 1'b1;
    a8 = 8'h00;   b8 = 8'h00;   sgn8 = 1'b0; in_valid8 = 1'b1;
    last4 = '0; last8 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold4", 8'({agb4, alb4, aeb4, out_valid4}), 8'd0);
      check("reset_hold8", 8'({agb8, alb8, aeb8, out_valid8}), 8'd0);
    end
    @(negedge clk);
    in_valid4 = 1'b0; in_valid8 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_idle4", 8'({agb4, alb4, aeb4, out_valid4}), 8'd0);

    // Directed WIDTH=4.
    do4(4'b0001, 4'b0100, 1'b0);
    do4(4'b0100, 4'b0001, 1'b0);
    do4(4'b1010, 4'b1010, 1'b0);
    do4(4'b1010, 4'b0001, 1'b1);
    do4(4'b1010, 4'b0001, 1'b0);
    do4(4'b0000, 4'b0000, 1'b0);
    do4(4'b1111, 4'b1111, 1'b1);
    do4(4'b1111, 4'b0000, 1'b0);
    do4(4'b1111, 4'b0000, 1'b1);
    do4(4'b1000, 4'b0111, 1'b1);
    do4(4'b1000, 4'b0111, 1'b0);

    // Directed WIDTH=8.
    do8(8'h80, 8'h7F, 1'b0);
    do8(8'h80, 8'h7F, 1'b1);
    do8(8'h35, 8'h36, 1'b0);
    do8(8'h36, 8'h35, 1'b1);
    do8(8'hFF, 8'h00, 1'b1);
    do8(8'hFF, 8'hFF, 1'b0);
    do8(8'h5A, 8'h4F, 1'b0);

    // Random operands, both modes.
    for (int i = 0; i < 24; i++) begin
      do4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      do8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Back-to-back valid transactions with no idle gap.
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0010; sgn4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    check("b2b_first4", 8'({agb4, alb4, aeb4, out_valid4}), 8'b1001);
    a4 = 4'b0010; b4 = 4'b0011;
    @(negedge clk);
    check("b2b_second4", 8'({agb4, alb4, aeb4, out_valid4}), 8'b0101);
    last4 = 3'b010;

    // Idle with unknown operands: out_valid drops, flags hold.
    in_valid4 = 1'b0; a4 = 'x; b4 = 'x;
    in_valid8 = 1'b0; a8 = 'x; b8 = 'x;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("idle_valid4", 8'(out_valid4), 8'd0);
      check("idle_hold4", 8'({agb4, alb4, aeb4}), 8'(last4));
      check("idle_hold8", 8'({agb8, alb8, aeb8}), 8'(last8));
    end

    // Asynchronous reset mid-cycle right after a transaction was sampled.
    @(negedge clk);
    a4 = 4'b0100; b4 = 4'b0001; sgn4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset4", 8'({agb4, alb4, aeb4, out_valid4}), 8'b1001);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset4", 8'({agb4, alb4, aeb4, out_valid4}), 8'd0);
    check("async_reset8", 8'({agb8, alb8, aeb8, out_valid8}), 8'd0);
    @(negedge clk);
    in_valid4 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_idle4", 8'({agb4, alb4, aeb4, out_valid4}), 8'd0);

    // Recovery after reset.
    do4(4'b0110, 4'b0110, 1'b1);
    do8(8'h01, 8'hFE, 1'b1);

    check("queue_empty4", 8'(exp_q4.size()), 8'd0);
    check("queue_empty8", 8'(exp_q8.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // One-hot invariant whenever a result is presented.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid4 === 1'b1) begin
      check("onehot4", 8'($countones({agb4, alb4, aeb4})), 8'd1);
    end
    if (reset === 1'b1 && out_valid8 === 1'b1) begin
      check("onehot8", 8'($countones({agb8, alb8, aeb8})), 8'd1);
    end
  end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
- Registered magnitude comparator for two WIDTH-bit operands. Produces one-hot greater, less and equal flags one clock after a valid input.
- Unsigned or two's-complement compare, selected per transaction.
- Sits in datapath control logic; flags feed FSM decisions downstream.
- Built from cascaded 4-bit slice comparators, MSB slice first.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived localparam giving the number of 4-bit slices; not user-settable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b and is_signed are sampled on this cycle.
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- agb  output  1  registered flag: A > B.
- alb  output  1  registered flag: A < B.
- aeb  output  1  registered flag: A == B.
- out_valid  output  1  flags correspond to the transaction sampled on the previous cycle.

Behaviour:
- Reset: while reset=0, agb, alb, aeb and out_valid are all 0, independent of clk. They stay 0 until the first clk edge after reset rises to 1 with in_valid=1.
- Latency: exactly 1 cycle. in_valid=1 at edge N gives the flags and out_valid=1 after edge N. Full throughput: one compare per cycle, no backpressure.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - agb, alb and aeb hold their last values (no toggling on idle cycles).
- Invariant: whenever out_valid=1, exactly one of agb, alb, aeb is 1. Outside reset, the flags are never all 0 after the first valid transaction.
- Unsigned mode: plain magnitude compare of a and b.
- Signed mode: invert the MSB of both operands before the unsigned compare (offset-binary trick). Sign handling is done this way only, not by subtraction.
- Slice cascade:
  - Operands are split into NSLICE nibbles.
  - Each slice takes cascade-in gt/lt/eq from the next-more-significant slice. The top slice gets cascade-in eq=1, gt=lt=0.
  - A slice passes gt or lt through unchanged if its cascade-in is gt or lt. Otherwise it resolves its own nibble: gt if a_nib > b_nib, lt if a_nib < b_nib, else eq.
  - The LSB slice outputs form the combinational result; it is registered in a single output stage.
- Boundaries:
  - All-zeros vs all-zeros gives aeb.
  - All-ones vs all-ones gives aeb.
  - Max vs 0: unsigned gives agb; signed gives alb, since all-ones is -1.
  - Signed most-negative (1000...) vs most-positive (0111...) gives alb.
- Reset mid-stream: reset asserted asynchronously clears all outputs immediately. A transaction sampled on the edge before assertion is discarded.
- X on a or b while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package holds:
  - typedef cmp_res_t, a struct of {gt, lt, eq};
  - constant CMP_EQ_INIT = {0,0,1};
  - constant SLICE_W = 4.
- One sub-module, comparator_slice: 4-bit combinational slice with cascade-in and cascade-out of type cmp_res_t. Instantiated NSLICE times with a generate loop.
- Top level contains the MSB inversion for signed mode, the cascade chain, and the output register stage.

Test Plan:
- Reset held low with a=4'b0001, b=4'b0100, in_valid=1 and clk running -> agb=alb=aeb=out_valid=0 throughout.
- Release reset; a=4'b0001, b=4'b0100, is_signed=0, in_valid=1 -> next cycle alb=1, agb=0, aeb=0, out_valid=1.
- a=4'b0100, b=4'b0001 -> agb=1.
- a=4'b1010, b=4'b1010 -> aeb=1.
- Signed: a=4'b1010 (-6), b=4'b0001, is_signed=1 -> alb=1. Same operands with is_signed=0 -> agb=1.
- Idle and reset: back-to-back valid compares, then in_valid=0 -> out_valid=0 and flags hold. Then assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
- WIDTH=8: a=8'h80, b=8'h7F -> unsigned agb=1, signed alb=1. a=8'h35, b=8'h36 (differs only in low slice) -> alb=1.
